acc_drain_reader: RTL
=====================

// Module: acc_drain_reader
// PURPOSE
//  Read side of the accumulator drain interface. On a start pulse, raises drain, captures the skewed per-column
//  accumulator rows from acc_out, de-skews them into whole rows, and buffers them in a row FIFO.
//  Emits rows on a valid/ready stream toward the output/writeback path, then pulses acc_clear so the next tile starts clean.
//  Sits between accumulator (acc_out) and the result DMA / output buffer.
// PARAMETERS
//  DEPTH          8                      rows per tile held in the accumulator; also row-FIFO depth
//  ARRAY_M        8                      lanes (columns) per row
//  DATA_WIDTH     32                     bits per lane
//  ACC_LAT        1                      cycles from drain rise to lane 0 of row 0 on acc_out
//  DATA_SET_WIDTH ARRAY_M*DATA_WIDTH     row width (derived)
// PORTS
//  clk        in   1                    clock, all logic on rising edge
//  reset      in   1                    asynchronous, active-low reset
//  start      in   1                    one-cycle request to drain a tile; ignored unless idle
//  num_cols   in   $clog2(ARRAY_M)+1    active lanes; sampled on accepted start
//  busy       out  1                    high from accepted start until done
//  done       out  1                    one-cycle pulse, tile fully streamed and cleared
//  drain      out  1                    to accumulator drain
//  acc_clear  out  1                    one-cycle pulse to accumulator acc_reset
//  acc_out    in   DATA_SET_WIDTH       skewed row data from accumulator
//  m_data     out  DATA_SET_WIDTH       de-skewed row; lane j at bits [j*DATA_WIDTH +: DATA_WIDTH]
//  m_valid    out  1                    m_data valid
//  m_ready    in   1                    downstream accept
//  m_last     out  1                    high with row DEPTH-1
// BEHAVIOUR
//  Reset (async, reset=0): state IDLE, FIFO empty, all counters 0, deskew regs 0.
//   Outputs busy/done/drain/acc_clear/m_valid/m_last = 0, m_data = 0.
//  Input timing (fixed contract): row r, lane j is valid on acc_out lane j at cycle ACC_LAT+r+j after drain rises.
//  FSM:
//   IDLE  -> DRAIN  on start; latch num_cols, clamped to ARRAY_M if larger; busy=1.
//   DRAIN -> drain=1 for exactly DEPTH+ARRAY_M-1 cycles.
//   DRAIN -> FLUSH  after the last capture cycle (ACC_LAT+DEPTH+ARRAY_M-2).
//   FLUSH -> CLEAR  when FIFO empty and last handshake done.
//   CLEAR -> IDLE   acc_clear=1 and done=1 for one cycle; busy drops the next cycle.
//  De-skew:
//   Lane j passes through ARRAY_M-1-j register stages, so all lanes of row r align at cycle ACC_LAT+r+ARRAY_M-1.
//   Row-valid is a capture counter 0..DEPTH-1 gated by that window.
//   Lanes j >= latched num_cols are forced to 0. num_cols=0 still emits DEPTH all-zero rows.
//  FIFO: DEPTH entries, each DATA_SET_WIDTH+1 bits (data plus last flag).
//   Drain cannot be stalled, so a write never meets a full FIFO. Full-on-write is an assertion failure.
//  Stream handshake:
//   m_valid = FIFO not empty. m_data/m_last stay stable while m_valid && !m_ready. Pop on m_valid && m_ready.
//   First-word latency: 1 cycle after a row is written (registered FIFO output).
//   Rows may stream during DRAIN. Write and pop in the same cycle are allowed; occupancy is unchanged.
//  Exactly DEPTH handshakes per tile; m_last on the DEPTH-th.
//  start while busy: ignored, no effect on the current tile.
//  Reset mid-operation: everything aborts immediately to the reset state. acc_clear is not issued.
//   The accumulator's own reset covers it.
//  Counter widths: capture/issue counters $clog2(DEPTH+ARRAY_M+ACC_LAT)+1; no wrap within a tile.
// STRUCTURE
//  Package acc_drain_pkg:
//   state enum {IDLE, DRAIN, FLUSH, CLEAR}
//   localparams for lane/row widths
//   DRAIN_CYCLES = DEPTH+ARRAY_M-1
//  Sub-module row_fifo: sync FIFO (WIDTH, DEPTH params), registered read, full/empty flags.
//  De-skew triangle and FSM stay in this module.
// TESTING
//  1. Acc model holds row r lane j = 100*r+j; num_cols=8, m_ready=1; start
//     -> 8 rows, m_data lane j = 100*r+j, m_last on row 7, acc_clear then done once.
//  2. num_cols=5, same data
//     -> lanes 5..7 read 0, lanes 0..4 correct, still 8 rows.
//  3. m_ready=0 for whole drain, then 1
//     -> FIFO fills to exactly 8, no overflow assertion, all 8 rows in order, data stable while stalled.
//  4. m_ready toggled every cycle during drain
//     -> order preserved, one pop per handshake, same-cycle write+pop leaves occupancy unchanged.
//  5. start pulsed again mid-DRAIN
//     -> ignored, exactly 8 rows and one done.
//  6. reset low in FLUSH with 3 rows queued
//     -> m_valid=0, busy=0, no acc_clear; a new start then yields a clean 8-row tile.

Source files
------------

// File: rtl/acc_drain_pkg.sv
// Shared types and default geometry for the accumulator drain reader.
package acc_drain_pkg;

  localparam int DEF_DEPTH          = 8;
  localparam int DEF_ARRAY_M        = 8;
  localparam int DEF_DATA_WIDTH     = 32;
  localparam int DEF_ACC_LAT        = 1;
  localparam int DEF_DATA_SET_WIDTH = DEF_ARRAY_M * DEF_DATA_WIDTH;
  localparam int DRAIN_CYCLES       = DEF_DEPTH + DEF_ARRAY_M - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2,
    CLEAR = 2'd3
  } state_e;

  function automatic int drain_cycles_f(input int depth, input int lanes);
    return depth + lanes - 1;
  endfunction

  // Wide enough that the cycle counter never wraps inside one tile.
  function automatic int cnt_width_f(input int depth, input int lanes, input int lat);
    return $clog2(depth + lanes + lat) + 1;
  endfunction

endpackage

// File: rtl/acc_drain_reader_chk.sv
// Runtime invariants of the drain reader.
module acc_drain_reader_chk (
  input logic clk,
  input logic reset,
  input logic fifo_wr,
  input logic fifo_full,
  input logic done,
  input logic acc_clear
);

  // The drain cannot be back-pressured, so the row FIFO must always have room.
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset) !(fifo_wr && fifo_full));

  a_clear_with_done: assert property (@(posedge clk) disable iff (!reset) (acc_clear == done));

endmodule

// File: rtl/acc_drain_reader_row_fifo.sv
// Synchronous row FIFO with a registered head word; empty/full flags from the occupancy count.
module row_fifo #(
  parameter int WIDTH = 257,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wptr_r;
  logic [PTR_W-1:0] rptr_r;
  logic [PTR_W-1:0] rptr_nxt_s;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_nxt_s;
  logic [WIDTH-1:0] dout_r;
  logic [WIDTH-1:0] dout_nxt_s;
  logic             valid_r;
  logic             push_s;
  logic             pop_s;

  function automatic logic [PTR_W-1:0] ptr_inc_f(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  assign full        = (count_r == CNT_W'(DEPTH));
  assign empty       = ~valid_r;
  assign rd_data     = dout_r;
  assign push_s      = wr_en & ~full;
  assign pop_s       = rd_en & valid_r;
  assign count_nxt_s = count_r + CNT_W'(push_s) - CNT_W'(pop_s);
  assign rptr_nxt_s  = pop_s ? ptr_inc_f(rptr_r) : rptr_r;

  // Next head word: the incoming row when it becomes the only entry, else the stored entry at the new read pointer.
  always_comb begin
    dout_nxt_s = dout_r;
    if (count_nxt_s == '0) begin
      dout_nxt_s = dout_r;
    end else if ((count_r - CNT_W'(pop_s)) == '0) begin
      dout_nxt_s = wr_data;
    end else begin
      dout_nxt_s = mem_r[rptr_nxt_s];
    end
  end

  // Row storage; contents are don't-care while unoccupied.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wptr_r] <= wr_data;
    end
  end

  // Pointers, occupancy and registered head.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
      dout_r  <= '0;
      valid_r <= 1'b0;
    end else begin
      if (push_s) begin
        wptr_r <= ptr_inc_f(wptr_r);
      end
      rptr_r  <= rptr_nxt_s;
      count_r <= count_nxt_s;
      dout_r  <= dout_nxt_s;
      valid_r <= (count_nxt_s != '0);
    end
  end

endmodule

// File: rtl/acc_drain_reader.sv
// Accumulator drain read side: drains a tile, de-skews columns into rows, and streams them out.
module acc_drain_reader
  import acc_drain_pkg::*;
#(
  parameter int DEPTH          = DEF_DEPTH,
  parameter int ARRAY_M        = DEF_ARRAY_M,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int ACC_LAT        = DEF_ACC_LAT,
  parameter int DATA_SET_WIDTH = ARRAY_M * DATA_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [$clog2(ARRAY_M):0]  num_cols,
  output logic                      busy,
  output logic                      done,
  output logic                      drain,
  output logic                      acc_clear,
  input  logic [DATA_SET_WIDTH-1:0] acc_out,
  output logic [DATA_SET_WIDTH-1:0] m_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic                      m_last
);

  localparam int NC_W      = $clog2(ARRAY_M) + 1;
  localparam int CNT_W     = cnt_width_f(DEPTH, ARRAY_M, ACC_LAT);
  localparam int DRAIN_CYC = drain_cycles_f(DEPTH, ARRAY_M);
  localparam int CAP_FIRST = ACC_LAT + ARRAY_M - 1;
  localparam int CAP_LAST  = CAP_FIRST + DEPTH - 1;

  state_e                    state_r;
  logic [CNT_W-1:0]          cnt_r;
  logic [CNT_W-1:0]          row_cnt_r;
  logic [NC_W-1:0]           ncols_r;
  logic                      busy_r;
  logic                      done_r;
  logic                      drain_r;
  logic                      clr_r;
  logic                      shift_en_s;
  logic                      wr_en_s;
  logic                      wr_last_s;
  logic                      fifo_empty_s;
  logic                      fifo_full_s;
  logic [DATA_WIDTH-1:0]     aligned_s [ARRAY_M];
  logic [DATA_SET_WIDTH-1:0] row_s;
  logic [DATA_SET_WIDTH:0]   fifo_dout_s;

  assign shift_en_s = (state_r == DRAIN);
  assign wr_en_s    = (state_r == DRAIN) && (cnt_r >= CNT_W'(CAP_FIRST));
  assign wr_last_s  = (row_cnt_r == CNT_W'(DEPTH - 1));

  // Lane j is delayed ARRAY_M-1-j cycles so every lane of a row lines up with the last lane.
  for (genvar j = 0; j < ARRAY_M; j++) begin : g_lane
    localparam int STAGES = ARRAY_M - 1 - j;
    logic [DATA_WIDTH-1:0] lane_in_s;
    assign lane_in_s = acc_out[j*DATA_WIDTH +: DATA_WIDTH];
    if (STAGES == 0) begin : g_pass
      assign aligned_s[j] = lane_in_s;
    end else begin : g_dly
      logic [DATA_WIDTH-1:0] stage_r [STAGES];
      // Skew-compensation shift chain for this lane.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int s = 0; s < STAGES; s++) begin
            stage_r[s] <= '0;
          end
        end else if (shift_en_s) begin
          stage_r[0] <= lane_in_s;
          for (int s = 1; s < STAGES; s++) begin
            stage_r[s] <= stage_r[s-1];
          end
        end
      end
      assign aligned_s[j] = stage_r[STAGES-1];
    end
  end

  // Assemble the aligned row, zeroing lanes beyond the active column count.
  always_comb begin
    row_s = '0;
    for (int j = 0; j < ARRAY_M; j++) begin
      if (NC_W'(j) < ncols_r) begin
        row_s[j*DATA_WIDTH +: DATA_WIDTH] = aligned_s[j];
      end else begin
        row_s[j*DATA_WIDTH +: DATA_WIDTH] = '0;
      end
    end
  end

  // Tile sequencer with registered control outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      row_cnt_r <= '0;
      ncols_r   <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      drain_r   <= 1'b0;
      clr_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          clr_r  <= 1'b0;
          if (start) begin
            state_r   <= DRAIN;
            busy_r    <= 1'b1;
            drain_r   <= 1'b1;
            cnt_r     <= '0;
            row_cnt_r <= '0;
            ncols_r   <= (num_cols > NC_W'(ARRAY_M)) ? NC_W'(ARRAY_M) : num_cols;
          end
        end
        DRAIN: begin
          cnt_r <= cnt_r + CNT_W'(1);
          if (cnt_r == CNT_W'(DRAIN_CYC - 1)) begin
            drain_r <= 1'b0;
          end
          if (wr_en_s) begin
            row_cnt_r <= row_cnt_r + CNT_W'(1);
          end
          if (cnt_r == CNT_W'(CAP_LAST)) begin
            state_r <= FLUSH;
          end
        end
        FLUSH: begin
          if (fifo_empty_s) begin
            state_r <= CLEAR;
            clr_r   <= 1'b1;
            done_r  <= 1'b1;
          end
        end
        CLEAR: begin
          state_r <= IDLE;
          clr_r   <= 1'b0;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          drain_r <= 1'b0;
          clr_r   <= 1'b0;
        end
      endcase
    end
  end

  row_fifo #(
    .WIDTH (DATA_SET_WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_row_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en_s),
    .wr_data ({wr_last_s, row_s}),
    .rd_en   (m_ready),
    .rd_data (fifo_dout_s),
    .empty   (fifo_empty_s),
    .full    (fifo_full_s)
  );

  acc_drain_reader_chk u_chk (
    .clk       (clk),
    .reset     (reset),
    .fifo_wr   (wr_en_s),
    .fifo_full (fifo_full_s),
    .done      (done_r),
    .acc_clear (clr_r)
  );

  assign busy      = busy_r;
  assign done      = done_r;
  assign drain     = drain_r;
  assign acc_clear = clr_r;
  assign m_valid   = ~fifo_empty_s;
  assign m_data    = fifo_dout_s[DATA_SET_WIDTH-1:0];
  assign m_last    = fifo_dout_s[DATA_SET_WIDTH];

endmodule
